fifo_read_streamer: RTL

//   Read-side drain engine for asynchronous_fifo, in the rclk domain.
//   - Pops words with r_en/empty, absorbs the FIFO's 1-cycle read latency, presents words as a valid/ready stream.
//   - Downstream backpressure never loses or duplicates a word.
//   - Owns the FIFO read port; nothing else may drive r_en.

---
 rtl/fifo_read_streamer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/fifo_read_streamer.sv
// ---------------------------------------------------------------------------
// fifo_read_streamer
//
// Read-side drain engine for an asynchronous FIFO, living entirely in the
// read clock domain. It pops words from the FIFO read port, absorbs the
// FIFO's one-cycle read latency into a small skid buffer, and presents the
// words downstream as a valid/ready stream. Backpressure never loses or
// duplicates a word. This block is the only driver of the FIFO read enable.
//
// Optional feature macro: FIFO_RD_CHECKSUM_EN
//   When defined, adds output rd_csum, a running XOR of every accepted word.
//   Flush does not clear it; reset does.
//
// Parameters
//   DATA_WIDTH  word width (must match the FIFO data width)
//   BUF_DEPTH   skid buffer entries, power of two, 2..8
//   CNT_WIDTH   width of the delivered-word counter
//
// Ports
//   rclk        read clock (only clock)
//   rrst        asynchronous reset, active high
//   enable      1 = fetch from FIFO, 0 = stop fetching and drain the buffer
//   flush       one-cycle pulse: discard buffered and in-flight words
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO read data, valid one rclk after fifo_r_en was high
//   fifo_r_en   FIFO read enable
//   m_valid     output word valid
//   m_data      output word
//   m_ready     downstream accepts when m_valid & m_ready
//   rd_count    number of words delivered (wraps)
//   busy        state machine is not idle
//   rd_csum     (FIFO_RD_CHECKSUM_EN only) XOR of all delivered words
// ---------------------------------------------------------------------------
module fifo_read_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  busy
`ifdef FIFO_RD_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] rd_csum
`endif
);

  localparam int IDX_W = $clog2(BUF_DEPTH);
  localparam int PTR_W = IDX_W + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]            state_reg;
  logic [1:0]            state_next;
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic                  inflight_reg;
  logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];

  logic [PTR_W-1:0]      occ;
  logic [PTR_W:0]        credit_used;
  logic                  accept;
  logic                  capture;

  // Pointers carry one extra MSB so a full buffer (occ == BUF_DEPTH) is
  // distinguishable from an empty one; the subtraction wraps naturally.
  assign occ     = wr_ptr_reg - rd_ptr_reg;
  assign m_valid = (occ != '0);
  assign m_data  = buf_mem[rd_ptr_reg[IDX_W-1:0]];
  assign accept  = m_valid & m_ready;

  // A word returning from a read issued before a flush is dropped.
  assign capture = inflight_reg & ~flush;

  // Slots committed after this edge: stored words plus the word in flight,
  // minus the word leaving on this edge. Counting the departing word lets a
  // two-entry buffer sustain one word per cycle; the freed slot is vacated
  // at the same edge the new read is issued, and the read data only lands
  // one edge later, so a slot is always guaranteed.
  assign credit_used = {1'b0, occ} + (PTR_W+1)'(inflight_reg) - (PTR_W+1)'(accept);

  assign fifo_r_en = (state_reg == RUN) & ~fifo_empty & ~flush &
                     (credit_used < (PTR_W+1)'(BUF_DEPTH));

  assign busy = (state_reg != IDLE);

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = enable ? RUN : IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (enable) state_next = RUN;
        RUN:     if (!enable) state_next = DRAIN;
        DRAIN: begin
          if (enable)
            state_next = RUN;
          else if ((occ == '0) && !inflight_reg)
            state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      inflight_reg <= 1'b0;
      rd_count     <= '0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= fifo_r_en;
      if (capture)
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      // Flush empties the buffer by catching the read pointer up to the
      // write pointer; an accept in the same cycle is still counted below.
      if (flush)
        rd_ptr_reg <= wr_ptr_reg;
      else if (accept)
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (accept)
        rd_count <= rd_count + CNT_WIDTH'(1);
    end
  end

  // Reset clears the storage so m_data reads zero out of reset.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      for (int i = 0; i < BUF_DEPTH; i++)
        buf_mem[i] <= '0;
    end else if (capture) begin
      buf_mem[wr_ptr_reg[IDX_W-1:0]] <= fifo_data;
    end
  end

`ifdef FIFO_RD_CHECKSUM_EN
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst)
      rd_csum <= '0;
    else if (accept)
      rd_csum <= rd_csum ^ m_data;
  end
`endif

endmodule
